// File: rtl/corrode_frame_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : corrode_frame_ctrl
// Description : Frame-level sequencer for the corrosion stage. Arms on camera
//               VSYNC and gates exactly H_ACT*V_ACT pixels into the corrosion
//               block. Host threshold/enable changes go through a shadow
//               register and take effect only at frame start. Counts corrosion
//               output blocks per frame. When VSYNC cuts a frame short, the
//               frame is padded with white pixels so that downstream counters
//               stay frame-aligned.
// Optional    : CORRODE_STAT_EN adds white_cnt (white output blocks per frame).
// Ports       : sys_clk/sys_rst_n       clock, async active-low reset
//               cfg_req/cfg_ack         4-phase host config handshake
//               cfg_en/cfg_err          requested enable / threshold
//               cam_vsync/valid/wb      camera pixel stream
//               crd_valid/wb/err        pixel stream + threshold to corrosion
//               crd_o_valid/crd_o_wb    corrosion block output
//               blk_cnt (white_cnt)     per-frame statistics
//               frame_done/frame_err    completion / abort pulses
//               busy                    frame in progress
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps

`ifndef OV5640_X
`define OV5640_X 640
`endif
`ifndef OV5640_Y
`define OV5640_Y 480
`endif

module corrode_frame_ctrl #(
  parameter int H_ACT = `OV5640_X,
  parameter int V_ACT = `OV5640_Y,
  parameter int PIX_W = 20,
  parameter int C_W   = 16,
  parameter int CNT_W = 16,
  parameter int DRAIN = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cfg_req,
  output logic             cfg_ack,
  input  logic             cfg_en,
  input  logic [C_W-1:0]   cfg_err,
  input  logic             cam_vsync,
  input  logic             cam_valid,
  input  logic             cam_wb,
  output logic             crd_valid,
  output logic             crd_wb,
  output logic [C_W-1:0]   crd_err,
  input  logic             crd_o_valid,
  input  logic             crd_o_wb,
  output logic [CNT_W-1:0] blk_cnt,
`ifdef CORRODE_STAT_EN
  output logic [CNT_W-1:0] white_cnt,
`endif
  output logic             frame_done,
  output logic             frame_err,
  output logic             busy
);

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(H_ACT * V_ACT - 1);
  localparam int               DR_W     = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [DR_W-1:0]  DR_LAST  = DR_W'(DRAIN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_ACTIVE = 3'd2,
    S_PAD    = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               vsync_q;
  logic               cfg_ack_q, cfg_ack_d;
  logic               sh_en_q, sh_en_d;
  logic [C_W-1:0]     sh_err_q, sh_err_d;
  logic [C_W-1:0]     crd_err_q, crd_err_d;
  logic               crd_valid_q, crd_valid_d;
  logic               crd_wb_q, crd_wb_d;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [DR_W-1:0]    drain_q, drain_d;
  logic               abort_q, abort_d;
  logic [CNT_W-1:0]   blk_run_q, blk_run_d;
  logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_err_q, frame_err_d;

  logic               w_vs_rise;
  logic               w_start;     // ARM -> ACTIVE this cycle
  logic               w_counting;  // statistics window open
  logic               w_done;      // clean frame completes this cycle
  logic [CNT_W-1:0]   w_blk_next;

  assign w_vs_rise  = cam_vsync & ~vsync_q;
  assign w_start    = (state_q == S_ARM) && w_vs_rise && sh_en_q;
  assign w_counting = (state_q == S_ACTIVE) || (state_q == S_PAD) || (state_q == S_DRAIN);
  assign w_done     = (state_q == S_DRAIN) && (drain_q == DR_LAST) && !abort_q;
  assign w_blk_next = (crd_o_valid && (blk_run_q != CNT_MAX)) ? blk_run_q + CNT_W'(1) : blk_run_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      vsync_q      <= 1'b0;
      cfg_ack_q    <= 1'b0;
      sh_en_q      <= 1'b0;
      sh_err_q     <= '0;
      crd_err_q    <= '0;
      crd_valid_q  <= 1'b0;
      crd_wb_q     <= 1'b0;
      pix_cnt_q    <= '0;
      drain_q      <= '0;
      abort_q      <= 1'b0;
      blk_run_q    <= '0;
      blk_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= cam_vsync;
      cfg_ack_q    <= cfg_ack_d;
      sh_en_q      <= sh_en_d;
      sh_err_q     <= sh_err_d;
      crd_err_q    <= crd_err_d;
      crd_valid_q  <= crd_valid_d;
      crd_wb_q     <= crd_wb_d;
      pix_cnt_q    <= pix_cnt_d;
      drain_q      <= drain_d;
      abort_q      <= abort_d;
      blk_run_q    <= blk_run_d;
      blk_cnt_q    <= blk_cnt_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cfg_ack_d    = cfg_ack_q;
    sh_en_d      = sh_en_q;
    sh_err_d     = sh_err_q;
    crd_err_d    = crd_err_q;
    crd_valid_d  = 1'b0;
    crd_wb_d     = 1'b0;
    pix_cnt_d    = pix_cnt_q;
    drain_d      = drain_q;
    abort_d      = abort_q;
    blk_run_d    = blk_run_q;
    blk_cnt_d    = blk_cnt_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    // Shadow config: accepted in any state, applied only at frame start.
    if (cfg_req && !cfg_ack_q) begin
      sh_en_d   = cfg_en;
      sh_err_d  = cfg_err;
      cfg_ack_d = 1'b1;
    end else if (!cfg_req) begin
      cfg_ack_d = 1'b0;
    end

    if (w_counting) begin
      blk_run_d = w_blk_next;
    end

    case (state_q)
      S_IDLE: begin
        if (sh_en_q) state_d = S_ARM;
      end
      S_ARM: begin
        if (w_vs_rise) begin
          crd_err_d = sh_err_q;
          if (sh_en_q) begin
            state_d   = S_ACTIVE;
            pix_cnt_d = '0;
            abort_d   = 1'b0;
            blk_run_d = '0;
          end else begin
            state_d   = S_IDLE;
          end
        end
      end
      S_ACTIVE: begin
        crd_valid_d = cam_valid;
        crd_wb_d    = cam_wb;
        if (cam_valid) pix_cnt_d = pix_cnt_q + PIX_W'(1);
        // A final pixel coinciding with VSYNC still completes the frame cleanly.
        if (cam_valid && (pix_cnt_q == PIX_LAST)) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else if (w_vs_rise) begin
          state_d = S_PAD;
        end
      end
      S_PAD: begin
        crd_valid_d = 1'b1;
        crd_wb_d    = 1'b1;
        pix_cnt_d   = pix_cnt_q + PIX_W'(1);
        if (pix_cnt_q >= PIX_LAST) begin
          state_d = S_DRAIN;
          drain_d = '0;
          abort_d = 1'b1;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + DR_W'(1);
        if (drain_q == DR_LAST) begin
          state_d = sh_en_q ? S_ARM : S_IDLE;
          if (abort_q) begin
            frame_err_d  = 1'b1;
          end else begin
            frame_done_d = 1'b1;
            blk_cnt_d    = w_blk_next;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef CORRODE_STAT_EN
  logic [CNT_W-1:0] wht_run_q, wht_run_d;
  logic [CNT_W-1:0] wht_cnt_q, wht_cnt_d;
  logic [CNT_W-1:0] w_wht_next;

  assign w_wht_next = (crd_o_valid && crd_o_wb && (wht_run_q != CNT_MAX)) ?
                      wht_run_q + CNT_W'(1) : wht_run_q;

  always_comb begin
    wht_run_d = wht_run_q;
    wht_cnt_d = wht_cnt_q;
    if (w_start)         wht_run_d = '0;
    else if (w_counting) wht_run_d = w_wht_next;
    if (w_done)          wht_cnt_d = w_wht_next;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wht_run_q <= '0;
      wht_cnt_q <= '0;
    end else begin
      wht_run_q <= wht_run_d;
      wht_cnt_q <= wht_cnt_d;
    end
  end

  assign white_cnt = wht_cnt_q;
`else
  // Without statistics only the block count is kept.
`endif

  assign cfg_ack    = cfg_ack_q;
  assign crd_valid  = crd_valid_q;
  assign crd_wb     = crd_wb_q;
  assign crd_err    = crd_err_q;
  assign blk_cnt    = blk_cnt_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = w_counting;

endmodule
`default_nettype wire
